frame_sync_detector: RTL and testbench

Parametrised successor to the fixed-pattern bit-stream FSM. It hunts a serial bit stream for a programmable PAT_W-bit sync word. It confirms that the word repeats every FRAME_LEN valid bits, then declares lock. Lock is held through up to UNLOCK_CNT-1 consecutive missed sync words, which gives hysteresis in both directions. The block sits directly behind the serial receive front end and feeds frame-aligned control.

---
 rtl/frame_sync_pkg.sv | 16 +
 rtl/pattern_shift_match.sv | 35 +++
 rtl/frame_sync_detector.sv | 132 +++++++++++++
 tb/tb_frame_sync_detector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// Shared types and sizing helpers for the frame sync detector.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2,
        MISS    = 2'd3
    } sync_state_e;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pattern_shift_match.sv
// Serial shift register with fill gate; flags a sync word on the completing bit.
module pattern_shift_match #(
    parameter int PAT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  sr;
    logic [PAT_W-1:0]  sr_next;
    logic [FILL_W-1:0] fill;
    logic              filled_next;

    assign sr_next     = {sr[PAT_W-2:0], din};
    assign filled_next = (fill >= FILL_W'(PAT_W - 1));
    assign hit         = din_valid && filled_next && (sr_next == pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            fill <= '0;
        end else if (din_valid) begin
            sr <= sr_next;
            // Saturates so the gate stays open until the next reset.
            if (fill != FILL_W'(PAT_W))
                fill <= fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/frame_sync_detector.sv
// Frame sync hunter: acquires, confirms and tracks a periodic sync word.
module frame_sync_detector
    import frame_sync_pkg::*;
#(
    parameter int PAT_W      = 7,
    parameter int FRAME_LEN  = 16,
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    output logic             lock,
    output logic [1:0]       state,
    output logic             match,
    output logic             frame_start
);
    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam int CONF_W = cnt_w(LOCK_CNT);
    localparam int MISS_W = cnt_w(UNLOCK_CNT);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
    localparam logic [CONF_W-1:0] CONF_LOCK = CONF_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_CNT);

    sync_state_e       st, st_n;
    logic [FCNT_W-1:0] fcnt, fcnt_n;
    logic [CONF_W-1:0] conf, conf_n;
    logic [MISS_W-1:0] miss, miss_n;
    logic              match_n, fs_n;
    logic              hit, bnd;

    pattern_shift_match #(.PAT_W(PAT_W)) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_valid(din_valid),
        .din      (din),
        .pattern  (pattern),
        .hit      (hit)
    );

    assign bnd   = (fcnt == FCNT_LAST);
    assign state = st;

    always_comb begin
        st_n    = st;
        fcnt_n  = fcnt;
        conf_n  = conf;
        miss_n  = miss;
        match_n = 1'b0;
        fs_n    = 1'b0;
        if (din_valid) begin
            fcnt_n = bnd ? '0 : fcnt + FCNT_W'(1);
            unique case (st)
                HUNT: begin
                    if (hit) begin
                        st_n    = PRESYNC;
                        conf_n  = CONF_W'(1);
                        fcnt_n  = '0;
                        match_n = 1'b1;
                    end
                end
                PRESYNC: begin
                    if (bnd && hit) begin
                        match_n = 1'b1;
                        if (conf + CONF_W'(1) == CONF_LOCK) begin
                            st_n   = SYNC;
                            conf_n = '0;
                        end else begin
                            conf_n = conf + CONF_W'(1);
                        end
                    end else if (bnd) begin
                        st_n   = HUNT;
                        conf_n = '0;
                    end
                end
                SYNC: begin
                    if (bnd) begin
                        fs_n = 1'b1;
                        if (hit) begin
                            match_n = 1'b1;
                        end else if (UNLOCK_CNT == 1) begin
                            st_n = HUNT;
                        end else begin
                            st_n   = MISS;
                            miss_n = MISS_W'(1);
                        end
                    end
                end
                MISS: begin
                    if (bnd) begin
                        fs_n = 1'b1;
                        if (hit) begin
                            st_n    = SYNC;
                            miss_n  = '0;
                            match_n = 1'b1;
                        end else if (miss + MISS_W'(1) == MISS_DROP) begin
                            st_n   = HUNT;
                            miss_n = '0;
                        end else begin
                            miss_n = miss + MISS_W'(1);
                        end
                    end
                end
                default: st_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= HUNT;
            fcnt        <= '0;
            conf        <= '0;
            miss        <= '0;
            lock        <= 1'b0;
            match       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            st          <= st_n;
            fcnt        <= fcnt_n;
            conf        <= conf_n;
            miss        <= miss_n;
            lock        <= (st_n == SYNC) || (st_n == MISS);
            match       <= match_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_frame_sync_detector.sv
// Randomized bench for frame_sync_detector against a bit-history reference model.
module tb_frame_sync_detector;

    localparam int PAT_W      = 7;
    localparam int FRAME_LEN  = 16;
    localparam int LOCK_CNT   = 2;
    localparam int UNLOCK_CNT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic [PAT_W-1:0] pattern = 7'b1001001;
    logic             lock;
    logic [1:0]       state;
    logic             match;
    logic             frame_start;

    int n_cmp = 0;
    int n_err = 0;

    frame_sync_detector #(
        .PAT_W     (PAT_W),
        .FRAME_LEN (FRAME_LEN),
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din        (din),
        .pattern    (pattern),
        .lock       (lock),
        .state      (state),
        .match      (match),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: bit history, frame anchor index, simple counts.
    int m_state, m_conf, m_miss, m_nvalid, m_anchor;
    bit m_match, m_fs;
    bit m_hist[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_conf = 0; m_miss = 0;
        m_nvalid = 0; m_anchor = 0;
        m_match = 0; m_fs = 0;
        m_hist.delete();
    endtask

    task automatic model_step(input bit v, input bit b);
        bit hit, bnd;
        m_match = 0;
        m_fs = 0;
        if (!v) return;
        m_hist.push_back(b);
        if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
        m_nvalid++;
        hit = (m_hist.size() == PAT_W);
        for (int i = 0; i < PAT_W; i++)
            if (m_hist[i] != pattern[PAT_W-1-i]) hit = 0;
        bnd = ((m_nvalid - m_anchor) % FRAME_LEN) == 0;
        case (m_state)
            0: if (hit) begin
                m_state = 1; m_conf = 1; m_anchor = m_nvalid; m_match = 1;
            end
            1: if (bnd) begin
                if (hit) begin
                    m_match = 1;
                    m_conf++;
                    if (m_conf == LOCK_CNT) m_state = 2;
                end else begin
                    m_state = 0; m_conf = 0;
                end
            end
            2: if (bnd) begin
                m_fs = 1;
                if (hit) m_match = 1;
                else begin
                    m_miss = 1;
                    m_state = (UNLOCK_CNT == 1) ? 0 : 3;
                    if (UNLOCK_CNT == 1) m_miss = 0;
                end
            end
            default: if (bnd) begin
                m_fs = 1;
                if (hit) begin
                    m_state = 2; m_miss = 0; m_match = 1;
                end else begin
                    m_miss++;
                    if (m_miss == UNLOCK_CNT) begin
                        m_state = 0; m_miss = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("state", 32'(state), 32'(m_state));
        chk("lock", 32'(lock), 32'(m_state >= 2));
        chk("match", 32'(match), 32'(m_match));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
    endtask

    task automatic send_bit(input bit v, input bit b);
        @(negedge clk);
        din_valid = v;
        din = b;
        @(posedge clk);
        #1;
        model_step(v, b);
        check_outputs();
    endtask

    task automatic send_frame(input logic [PAT_W-1:0] sw, input int max_gap,
                              input bit rand_fill);
        bit b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            repeat ($urandom_range(0, max_gap))
                send_bit(1'b0, 1'($urandom_range(0, 1)));
            if (i < PAT_W) b = sw[PAT_W-1-i];
            else b = rand_fill ? 1'($urandom_range(0, 1)) : 1'b0;
            send_bit(1'b1, b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
    endtask

    task automatic lock_up();
        do_reset();
        repeat (3) send_frame(7'b1001001, 0, 1'b0);
        chk("lock_up_state", 32'(state), 32'd2);
    endtask

    logic [15:0] fr;
    logic [PAT_W-1:0] bad;

    initial begin
        model_reset();
        fr = 16'b1001001_000000000;

        // Acquisition timing from reset.
        do_reset();
        for (int i = 0; i < 48; i++) begin
            send_bit(1'b1, fr[15 - (i % 16)]);
            if (i == 6) begin
                chk("s1_state_b7", 32'(state), 32'd1);
                chk("s1_match_b7", 32'(match), 32'd1);
            end
            if (i == 22) begin
                chk("s1_state_b23", 32'(state), 32'd2);
                chk("s1_lock_b23", 32'(lock), 32'd1);
            end
            if (i == 38) begin
                chk("s1_match_b39", 32'(match), 32'd1);
                chk("s1_fs_b39", 32'(frame_start), 32'd1);
            end
        end

        // Fill gate with an all-zero sync word.
        pattern = '0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1, 1'b0);
            if (i < 6) chk("s2_nomatch", 32'(match), 32'd0);
        end
        chk("s2_match_b7", 32'(match), 32'd1);
        chk("s2_state_b7", 32'(state), 32'd1);
        pattern = 7'b1001001;

        // Single corrupted sync word.
        lock_up();
        send_frame(7'b1001000, 0, 1'b0);
        chk("s3_state_miss", 32'(state), 32'd3);
        chk("s3_lock_miss", 32'(lock), 32'd1);
        send_frame(7'b1001001, 0, 1'b0);
        chk("s3_state_back", 32'(state), 32'd2);

        // Three misses drop lock; two good frames regain it.
        lock_up();
        send_frame(7'b1001000, 0, 1'b0);
        chk("s4_miss1", 32'(state), 32'd3);
        send_frame(7'b1001000, 0, 1'b0);
        chk("s4_miss2", 32'(state), 32'd3);
        send_frame(7'b1001000, 0, 1'b0);
        chk("s4_hunt", 32'(state), 32'd0);
        chk("s4_unlock", 32'(lock), 32'd0);
        send_frame(7'b1001001, 0, 1'b0);
        chk("s4_presync", 32'(state), 32'd1);
        send_frame(7'b1001001, 0, 1'b0);
        chk("s4_relock", 32'(lock), 32'd1);

        // Valid gaps inside frames.
        lock_up();
        for (int f = 0; f < 6; f++) begin
            send_frame(7'b1001001, 5, 1'b0);
            chk("s5_lock", 32'(lock), 32'd1);
        end

        // Asynchronous reset while locked.
        lock_up();
        send_frame(7'b1001001, 0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1, fr[15 - i]);
        chk("s6_match_pre", 32'(match), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_state", 32'(state), 32'd0);
        chk("s6_async_lock", 32'(lock), 32'd0);
        chk("s6_async_match", 32'(match), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1, fr[15 - i]);
            if (i < 6) chk("s6_nomatch", 32'(match), 32'd0);
        end
        chk("s6_rehunt", 32'(match), 32'd1);

        // Random traffic: corrupted words, random fill, random gaps.
        do_reset();
        for (int f = 0; f < 80; f++) begin
            bad = pattern;
            if ($urandom_range(0, 3) == 0)
                bad[$urandom_range(0, PAT_W - 1)] ^= 1'b1;
            send_frame(bad, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 19) == 0)
                repeat ($urandom_range(1, 9))
                    send_bit(1'b1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
